ol_pwm_softstart: RTL and testbench

- Parametrised open-loop complementary PWM generator for half-bridge SMPS stages.
- Adds the following to the existing fixed open-loop path:
  - programmable period;
  - independent leading-edge dead-times;
  - shadow-register updates at period boundaries (glitch-free);
  - soft-start ramp of on-time toward the target.
- Sits between the switch/register decode logic and the gate-driver pins.

---
 rtl/ol_pwm_softstart.sv | 161 ++++++++++++++++
 tb/tb_ol_pwm_softstart.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ol_pwm_softstart.sv
// rtl/ol_pwm_softstart.sv - open-loop complementary PWM with dead-times, shadowed settings and soft-start
module ol_pwm_softstart #(
  parameter int CNT_W      = 11,
  parameter int DT_W       = 5,
  parameter int SS_W       = 6,
  parameter int MIN_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_ton,
  input  logic [DT_W-1:0]  i_dt1,
  input  logic [DT_W-1:0]  i_dt2,
  input  logic [SS_W-1:0]  i_ss_step,
  output logic             o_c1,
  output logic             o_c2,
  output logic             o_cycle_start,
  output logic             o_ss_done
);

  localparam logic [CNT_W-1:0] MIN_PER = CNT_W'(MIN_PERIOD);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  // period counter and its next value
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // shadow registers, valid for the period currently in progress
  logic [CNT_W-1:0] per_s;
  logic [CNT_W-1:0] ton_t;
  logic [CNT_W-1:0] ton_eff;
  logic [DT_W-1:0]  dt1_s;
  logic [DT_W-1:0]  dt2_s;

  // values that would be captured at the coming period boundary
  logic [CNT_W-1:0] per_ld;
  logic [CNT_W-1:0] ton_t_ld;
  logic [CNT_W-1:0] ton_eff_ld;
  logic [CNT_W:0]   ramp_sum;

  // settings seen by the decoder this cycle: at cnt == 0 the freshly
  // loaded values already apply, so the first cycle of every period is
  // decoded with the same settings as the rest of that period
  logic             at_bound;
  logic [CNT_W-1:0] per_cur;
  logic [CNT_W-1:0] ton_t_cur;
  logic [CNT_W-1:0] ton_eff_cur;
  logic [DT_W-1:0]  dt1_cur;
  logic [DT_W-1:0]  dt2_cur;
  logic [CNT_W:0]   c2_start;

  // decoded gate levels, registered into the output flops
  logic c1_d;
  logic c2_d;
  logic cs_d;
  logic done_d;

  assign at_bound = (state == RUN) && (cnt == '0);

  // clamp requests and run one soft-start step for the next period
  always_comb begin
    per_ld     = (i_period < MIN_PER) ? MIN_PER : i_period;
    ton_t_ld   = (i_ton > per_ld) ? per_ld : i_ton;
    ramp_sum   = {1'b0, ton_eff} + (CNT_W+1)'(i_ss_step);
    ton_eff_ld = ton_t_ld;
    if (i_ss_step != '0 && ramp_sum < {1'b0, ton_t_ld}) begin
      ton_eff_ld = ramp_sum[CNT_W-1:0];
    end
  end

  // select live settings: new ones on the boundary cycle, shadows otherwise
  always_comb begin
    per_cur     = at_bound ? per_ld     : per_s;
    ton_t_cur   = at_bound ? ton_t_ld   : ton_t;
    ton_eff_cur = at_bound ? ton_eff_ld : ton_eff;
    dt1_cur     = at_bound ? i_dt1      : dt1_s;
    dt2_cur     = at_bound ? i_dt2      : dt2_s;
    c2_start    = {1'b0, ton_eff_cur} + (CNT_W+1)'(dt2_cur);
  end

  // next-state, counter and gate decode; c2 cannot start before ton_eff ends
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    c1_d      = 1'b0;
    c2_d      = 1'b0;
    cs_d      = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = (cnt == per_cur - 1'b1) ? '0 : cnt + 1'b1;
          c1_d    = (cnt >= CNT_W'(dt1_cur)) && (cnt < ton_eff_cur);
          c2_d    = ({1'b0, cnt} >= c2_start) && (cnt < per_cur);
          cs_d    = at_bound;
          done_d  = (ton_eff_cur == ton_t_cur);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // capture shadows at the boundary; leaving RUN restarts the ramp from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_s   <= '0;
      ton_t   <= '0;
      ton_eff <= '0;
      dt1_s   <= '0;
      dt2_s   <= '0;
    end else if (at_bound && enable) begin
      per_s   <= per_ld;
      ton_t   <= ton_t_ld;
      ton_eff <= ton_eff_ld;
      dt1_s   <= i_dt1;
      dt2_s   <= i_dt2;
    end else if (state == RUN && !enable) begin
      ton_eff <= '0;
    end
  end

  // counter and registered outputs, one clock behind the counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      o_c1          <= 1'b0;
      o_c2          <= 1'b0;
      o_cycle_start <= 1'b0;
      o_ss_done     <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      o_c1          <= c1_d;
      o_c2          <= c2_d;
      o_cycle_start <= cs_d;
      o_ss_done     <= done_d;
    end
  end

endmodule

// File: tb/tb_ol_pwm_softstart.sv
// tb/tb_ol_pwm_softstart.sv - directed and table-driven checks for ol_pwm_softstart
module tb_ol_pwm_softstart;

  localparam int CNT_W = 11;
  localparam int DT_W  = 5;
  localparam int SS_W  = 6;
  localparam int LIMIT = 5000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] i_period = '0;
  logic [CNT_W-1:0] i_ton = '0;
  logic [DT_W-1:0]  i_dt1 = '0;
  logic [DT_W-1:0]  i_dt2 = '0;
  logic [SS_W-1:0]  i_ss_step = '0;
  logic             o_c1, o_c2, o_cycle_start, o_ss_done;

  int n_chk  = 0;
  int n_fail = 0;

  ol_pwm_softstart #(.CNT_W(CNT_W), .DT_W(DT_W), .SS_W(SS_W), .MIN_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .i_period(i_period), .i_ton(i_ton), .i_dt1(i_dt1), .i_dt2(i_dt2),
    .i_ss_step(i_ss_step),
    .o_c1(o_c1), .o_c2(o_c2), .o_cycle_start(o_cycle_start), .o_ss_done(o_ss_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per, ton, dt1, dt2;
    int e_per, e_c1w, e_c1f, e_c2w, e_c2f;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("no_overlap", int'(o_c1 & o_c2), 0);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic setup(input int per, input int ton, input int dt1, input int dt2, input int step);
    i_period  = CNT_W'(per);
    i_ton     = CNT_W'(ton);
    i_dt1     = DT_W'(dt1);
    i_dt2     = DT_W'(dt2);
    i_ss_step = SS_W'(step);
  endtask

  // Measures one output period starting at the next o_cycle_start.
  // Indices are counter values; -1 means the gate never rose.
  // chg_at >= 0 moves i_ton to chg_ton while the counter is at chg_at+1.
  task automatic measure(input int chg_at, input int chg_ton,
                         output int per, output int c1w, output int c1f,
                         output int c2w, output int c2f, output int done, output int ok);
    int t;
    t = 0; ok = 1; per = 0; c1w = 0; c2w = 0; c1f = -1; c2f = -1; done = 0;
    while (!o_cycle_start && t < LIMIT) begin
      tick();
      t++;
    end
    if (!o_cycle_start) begin
      ok = 0;
      return;
    end
    done = int'(o_ss_done);
    do begin
      if (o_c1) begin c1w++; if (c1f < 0) c1f = per; end
      if (o_c2) begin c2w++; if (c2f < 0) c2f = per; end
      if (per == chg_at) i_ton = CNT_W'(chg_ton);
      per++;
      tick();
    end while (!o_cycle_start && per < LIMIT);
    if (!o_cycle_start) ok = 0;
  endtask

  int per, c1w, c1f, c2w, c2f, done, ok, t;
  int ss_c1w[5];
  int ss_c2w[5];
  int ss_done[5];

  initial begin
    vecs[0] = '{100,  40,  5,  5, 100, 35,  5, 55, 45};
    vecs[1] = '{  2,   1,  0,  0,   4,  1,  0,  3,  1};
    vecs[2] = '{100, 500,  5,  5, 100, 95,  5,  0, -1};
    vecs[3] = '{100,  20, 31,  3, 100,  0, -1, 77, 23};
    vecs[4] = '{ 10,  10,  0,  0,  10, 10,  0,  0, -1};
    vecs[5] = '{ 50,   0,  0,  2,  50,  0, -1, 48,  2};
    vecs[6] = '{ 64,  32, 31, 31,  64,  1, 31,  1, 63};
    ss_c1w  = '{10, 20, 30, 40, 40};
    ss_c2w  = '{90, 80, 70, 60, 60};
    ss_done = '{0, 0, 0, 1, 1};

    // reset state, and enable low keeps everything off
    do_reset();
    check("reset_c1", int'(o_c1), 0);
    check("reset_c2", int'(o_c2), 0);
    check("reset_cs", int'(o_cycle_start), 0);
    check("reset_done", int'(o_ss_done), 0);
    setup(100, 40, 5, 5, 0);
    for (int i = 0; i < 5; i++) tick();
    check("idle_c1", int'(o_c1), 0);
    check("idle_c2", int'(o_c2), 0);
    check("idle_cs", int'(o_cycle_start), 0);

    // fixed-operation table, step 0: two periods per row
    for (int v = 0; v < 7; v++) begin
      do_reset();
      setup(vecs[v].per, vecs[v].ton, vecs[v].dt1, vecs[v].dt2, 0);
      enable = 1'b1;
      for (int p = 0; p < 2; p++) begin
        measure(-1, 0, per, c1w, c1f, c2w, c2f, done, ok);
        check($sformatf("vec%0d_p%0d_timeout", v, p), ok, 1);
        check($sformatf("vec%0d_p%0d_period", v, p), per, vecs[v].e_per);
        check($sformatf("vec%0d_p%0d_c1_width", v, p), c1w, vecs[v].e_c1w);
        check($sformatf("vec%0d_p%0d_c1_first", v, p), c1f, vecs[v].e_c1f);
        check($sformatf("vec%0d_p%0d_c2_width", v, p), c2w, vecs[v].e_c2w);
        check($sformatf("vec%0d_p%0d_c2_first", v, p), c2f, vecs[v].e_c2f);
        check($sformatf("vec%0d_p%0d_ss_done", v, p), done, 1);
      end
    end

    // soft-start ramp 10,20,30,40,40
    do_reset();
    setup(100, 40, 0, 0, 10);
    enable = 1'b1;
    for (int p = 0; p < 5; p++) begin
      measure(-1, 0, per, c1w, c1f, c2w, c2f, done, ok);
      check($sformatf("ss_p%0d_timeout", p), ok, 1);
      check($sformatf("ss_p%0d_c1_width", p), c1w, ss_c1w[p]);
      check($sformatf("ss_p%0d_c2_width", p), c2w, ss_c2w[p]);
      check($sformatf("ss_p%0d_done", p), done, ss_done[p]);
    end

    // ton change mid-period only applies from the next boundary
    do_reset();
    setup(100, 40, 5, 5, 0);
    enable = 1'b1;
    measure(49, 60, per, c1w, c1f, c2w, c2f, done, ok);
    check("bnd_cur_timeout", ok, 1);
    check("bnd_cur_c1_width", c1w, 35);
    check("bnd_cur_c2_first", c2f, 45);
    measure(-1, 0, per, c1w, c1f, c2w, c2f, done, ok);
    check("bnd_next_timeout", ok, 1);
    check("bnd_next_c1_first", c1f, 5);
    check("bnd_next_c1_width", c1w, 55);
    check("bnd_next_c2_first", c2f, 65);
    check("bnd_next_c2_width", c2w, 35);

    // enable drop at cnt 30 of the second ramp period, then restart
    do_reset();
    setup(100, 40, 0, 0, 10);
    enable = 1'b1;
    measure(-1, 0, per, c1w, c1f, c2w, c2f, done, ok);
    check("en_p0_c1_width", c1w, 10);
    for (int i = 0; i < 29; i++) tick();
    check("en_before_drop_c2", int'(o_c2), 1);
    enable = 1'b0;
    tick();
    check("en_drop_c1", int'(o_c1), 0);
    check("en_drop_c2", int'(o_c2), 0);
    check("en_drop_done", int'(o_ss_done), 0);
    for (int i = 0; i < 3; i++) tick();
    enable = 1'b1;
    measure(-1, 0, per, c1w, c1f, c2w, c2f, done, ok);
    check("en_restart_timeout", ok, 1);
    check("en_restart_c1_width", c1w, 10);
    check("en_restart_done", done, 0);

    // asynchronous reset while c1 is high
    t = 0;
    while (!o_c1 && t < LIMIT) begin
      tick();
      t++;
    end
    check("rst_c1_seen", int'(o_c1), 1);
    rst = 1'b1;
    #1;
    check("rst_async_c1", int'(o_c1), 0);
    check("rst_async_c2", int'(o_c2), 0);
    check("rst_async_cs", int'(o_cycle_start), 0);
    tick();
    tick();
    rst = 1'b0;
    measure(-1, 0, per, c1w, c1f, c2w, c2f, done, ok);
    check("rst_after_timeout", ok, 1);
    check("rst_after_c1_width", c1w, 10);
    check("rst_after_c1_first", c1f, 0);

    // random inputs: overlap checked on every cycle by tick()
    for (int i = 0; i < 10000; i++) begin
      i_period  = CNT_W'($urandom_range(0, 200));
      i_ton     = CNT_W'($urandom_range(0, 255));
      i_dt1     = DT_W'($urandom_range(0, 31));
      i_dt2     = DT_W'($urandom_range(0, 31));
      i_ss_step = SS_W'($urandom_range(0, 63));
      enable    = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
